// File: rtl/random_word_arbiter.sv
// random_word_arbiter: two-requester round-robin arbiter that assembles
// WORD_W-bit random words from a free-running external LFSR bit stream.
module random_word_arbiter #(
  parameter int          WORD_W = 8,
  parameter logic [31:0] SEED   = 32'hACE12024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  output logic [1:0]        grant,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WORD_W-1:0] rsp_word,
  input  logic              reseed_req,
  input  logic [31:0]       reseed_value,
  output logic              reseed_ack,
  output logic [31:0]       lfsr_seed,
  output logic              lfsr_load_seed,
  input  logic              lfsr_bit
);

  localparam int CW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_W - 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOAD,
    GATHER,
    PRESENT
  } state_t;

  state_t        state_q;
  logic          ptr_q;
  logic [CW-1:0] cnt_q;
  logic          win_d;
  logic [31:0]   seed_d;

  // Round-robin pick: pointer owner wins if asking, else the other one.
  always_comb begin
    win_d = ptr_q;
    if (!req[ptr_q]) begin
      win_d = ~ptr_q;
    end
  end

  // A zero seed would lock the LFSR, so fall back to the default.
  always_comb begin
    seed_d = reseed_value;
    if (reseed_value == 32'd0) begin
      seed_d = SEED;
    end
  end

  // Main FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= INIT;
      grant          <= 2'b00;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_word       <= '0;
      reseed_ack     <= 1'b0;
      lfsr_load_seed <= 1'b0;
      lfsr_seed      <= SEED;
      ptr_q          <= 1'b0;
      cnt_q          <= '0;
    end else begin
      lfsr_load_seed <= 1'b0;
      reseed_ack     <= 1'b0;
      unique case (state_q)
        INIT: begin
          lfsr_load_seed <= 1'b1;
          lfsr_seed      <= SEED;
          state_q        <= IDLE;
        end
        IDLE: begin
          if (reseed_req) begin
            lfsr_load_seed <= 1'b1;
            reseed_ack     <= 1'b1;
            lfsr_seed      <= seed_d;
            state_q        <= LOAD;
          end else if (req != 2'b00) begin
            grant    <= win_d ? 2'b10 : 2'b01;
            rsp_id   <= win_d;
            cnt_q    <= '0;
            rsp_word <= '0;
            state_q  <= GATHER;
          end
        end
        LOAD: begin
          state_q <= IDLE;
        end
        GATHER: begin
          rsp_word <= {rsp_word[WORD_W-2:0], lfsr_bit};
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            rsp_valid <= 1'b1;
            state_q   <= PRESENT;
          end
        end
        PRESENT: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            grant     <= 2'b00;
            ptr_q     <= ~rsp_id;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

endmodule
